// File: rtl/mrmw_mem_fwd.sv
// Multi-read/multi-write memory with per-lane write masks, highest-index-writer
// priority, conflict flagging, selectable read latency/RDW behaviour and post-reset clear.
module mrmw_mem_fwd #(
  parameter int DEPTH          = 16,
  parameter int ADDR_BITS      = 4,
  parameter int WIDTH          = 8,
  parameter int READERS        = 3,
  parameter int WRITERS        = 3,
  parameter int MASK_GRAN      = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int LANES         = WIDTH / MASK_GRAN
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [READERS-1:0]             read_ens,
  input  logic [ADDR_BITS*READERS-1:0]   read_addrs,
  output logic [WIDTH*READERS-1:0]       read_datas,
  output logic [READERS-1:0]             read_valids,
  input  logic [WRITERS-1:0]             write_ens,
  input  logic [LANES*WRITERS-1:0]       write_masks,
  input  logic [ADDR_BITS*WRITERS-1:0]   write_addrs,
  input  logic [WIDTH*WRITERS-1:0]       write_datas,
  output logic                           ready,
  output logic                           write_conflict
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   clear_addr, clear_addr_next;
  logic            conflict_next;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WRITERS-1:0][ADDR_BITS-1:0] waddr;
  logic [WRITERS-1:0][LANES-1:0]     wlane;
  logic [WRITERS-1:0][WIDTH-1:0]     wdata;
  logic [READERS-1:0][ADDR_BITS-1:0] raddr;
  logic [READERS-1:0][WIDTH-1:0]     rd_old, rd_new, rd_sel;
  logic [READERS-1:0]                rd_fire;

  assign ready = (state == RUN);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= CLEAR;
      clear_addr     <= '0;
      write_conflict <= 1'b0;
    end else begin
      state          <= state_next;
      clear_addr     <= clear_addr_next;
      write_conflict <= conflict_next;
    end
  end

  always_comb begin
    state_next      = state;
    clear_addr_next = clear_addr;
    case (state)
      CLEAR: begin
        if (CLEAR_ON_RESET == 0) begin
          state_next = RUN;
        end else if (clear_addr == IW'(DEPTH - 1)) begin
          state_next      = RUN;
          clear_addr_next = '0;
        end else begin
          clear_addr_next = clear_addr + 1'b1;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  // wlane folds enable, mask, address range and ready into one per-lane strobe.
  always_comb begin
    for (int unsigned w = 0; w < WRITERS; w++) begin
      waddr[w] = write_addrs[w*ADDR_BITS +: ADDR_BITS];
      wdata[w] = write_datas[w*WIDTH +: WIDTH];
      wlane[w] = '0;
      if (write_ens[w] && ready && reset && (32'(waddr[w]) < DEPTH))
        wlane[w] = write_masks[w*LANES +: LANES];
    end
    for (int unsigned k = 0; k < READERS; k++)
      raddr[k] = read_addrs[k*ADDR_BITS +: ADDR_BITS];
  end

  always_comb begin
    conflict_next = 1'b0;
    for (int unsigned i = 0; i < WRITERS; i++)
      for (int unsigned j = i + 1; j < WRITERS; j++)
        if (waddr[i] == waddr[j] && |(wlane[i] & wlane[j]))
          conflict_next = 1'b1;
  end

  // Ascending writer order: the later non-blocking assignment wins per lane.
  always_ff @(posedge clock) begin
    if (CLEAR_ON_RESET != 0 && state == CLEAR && reset)
      mem[clear_addr] <= '0;
    for (int unsigned w = 0; w < WRITERS; w++)
      for (int unsigned l = 0; l < LANES; l++)
        if (wlane[w][l])
          mem[IW'(waddr[w])][l*MASK_GRAN +: MASK_GRAN] <= wdata[w][l*MASK_GRAN +: MASK_GRAN];
  end

  // rd_new mirrors the write priority so RDW_MODE=1 sees the post-edge word.
  always_comb begin
    for (int unsigned k = 0; k < READERS; k++) begin
      rd_old[k] = '0;
      if (32'(raddr[k]) < DEPTH)
        rd_old[k] = mem[IW'(raddr[k])];
      rd_new[k] = rd_old[k];
      for (int unsigned w = 0; w < WRITERS; w++)
        for (int unsigned l = 0; l < LANES; l++)
          if (wlane[w][l] && waddr[w] == raddr[k])
            rd_new[k][l*MASK_GRAN +: MASK_GRAN] = wdata[w][l*MASK_GRAN +: MASK_GRAN];
      rd_sel[k] = (RDW_MODE != 0) ? rd_new[k] : rd_old[k];
    end
    rd_fire = read_ens & {READERS{ready}};
  end

  if (READ_LATENCY == 0) begin : g_lat0
    assign read_valids = rd_fire;
    assign read_datas  = ready ? rd_old : '0;
  end else begin : g_reg
    logic [READERS-1:0][WIDTH-1:0] s1_data;
    logic [READERS-1:0]            s1_valid;

    always_ff @(posedge clock) begin
      if (!reset) begin
        s1_data  <= '0;
        s1_valid <= '0;
      end else begin
        s1_valid <= rd_fire;
        for (int unsigned k = 0; k < READERS; k++)
          if (rd_fire[k]) s1_data[k] <= rd_sel[k];
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [READERS-1:0][WIDTH-1:0] s2_data;
      logic [READERS-1:0]            s2_valid;

      always_ff @(posedge clock) begin
        if (!reset) begin
          s2_data  <= '0;
          s2_valid <= '0;
        end else begin
          s2_valid <= s1_valid;
          for (int unsigned k = 0; k < READERS; k++)
            if (s1_valid[k]) s2_data[k] <= s1_data[k];
        end
      end

      assign read_valids = s2_valid;
      assign read_datas  = s2_data;
    end else begin : g_lat1
      assign read_valids = s1_valid;
      assign read_datas  = s1_data;
    end
  end

endmodule

// File: tb/tb_mrmw_mem_fwd.sv
// Directed bench for mrmw_mem_fwd: four configurations share one stimulus stream
// (latency 1/RDW old, latency 2/RDW new, latency 0, and no-clear).
module tb_mrmw_mem_fwd;

  localparam int A = 5;
  localparam int W = 16;
  localparam int R = 3;
  localparam int WR = 3;
  localparam int L = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [R-1:0]      ren   = '0;
  logic [A*R-1:0]    raddr = '0;
  logic [WR-1:0]     wen   = '0;
  logic [L*WR-1:0]   wmask = '0;
  logic [A*WR-1:0]   waddr = '0;
  logic [W*WR-1:0]   wdata = '0;

  logic [W*R-1:0] l1_rdata, l2_rdata, l0_rdata, nc_rdata;
  logic [R-1:0]   l1_rvalid, l2_rvalid, l0_rvalid, nc_rvalid;
  logic           l1_ready, l2_ready, l0_ready, nc_ready;
  logic           l1_conf, l2_conf, l0_conf, nc_conf;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clock = ~clock;

  mrmw_mem_fwd #(.DEPTH(16), .ADDR_BITS(A), .WIDTH(W), .READERS(R), .WRITERS(WR), .MASK_GRAN(8),
                 .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_l1 (
    .clock(clock), .reset(reset), .read_ens(ren), .read_addrs(raddr), .read_datas(l1_rdata),
    .read_valids(l1_rvalid), .write_ens(wen), .write_masks(wmask), .write_addrs(waddr),
    .write_datas(wdata), .ready(l1_ready), .write_conflict(l1_conf));

  mrmw_mem_fwd #(.DEPTH(16), .ADDR_BITS(A), .WIDTH(W), .READERS(R), .WRITERS(WR), .MASK_GRAN(8),
                 .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_l2 (
    .clock(clock), .reset(reset), .read_ens(ren), .read_addrs(raddr), .read_datas(l2_rdata),
    .read_valids(l2_rvalid), .write_ens(wen), .write_masks(wmask), .write_addrs(waddr),
    .write_datas(wdata), .ready(l2_ready), .write_conflict(l2_conf));

  mrmw_mem_fwd #(.DEPTH(16), .ADDR_BITS(A), .WIDTH(W), .READERS(R), .WRITERS(WR), .MASK_GRAN(8),
                 .READ_LATENCY(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_l0 (
    .clock(clock), .reset(reset), .read_ens(ren), .read_addrs(raddr), .read_datas(l0_rdata),
    .read_valids(l0_rvalid), .write_ens(wen), .write_masks(wmask), .write_addrs(waddr),
    .write_datas(wdata), .ready(l0_ready), .write_conflict(l0_conf));

  mrmw_mem_fwd #(.DEPTH(16), .ADDR_BITS(A), .WIDTH(W), .READERS(R), .WRITERS(WR), .MASK_GRAN(8),
                 .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u_nc (
    .clock(clock), .reset(reset), .read_ens(ren), .read_addrs(raddr), .read_datas(nc_rdata),
    .read_valids(nc_rvalid), .write_ens(wen), .write_masks(wmask), .write_addrs(waddr),
    .write_datas(wdata), .ready(nc_ready), .write_conflict(nc_conf));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wen = '0;
    ren = '0;
  endtask

  task automatic wr(input int w, input logic [A-1:0] a, input logic [L-1:0] m, input logic [W-1:0] d);
    wen[w]          = 1'b1;
    waddr[w*A +: A] = a;
    wmask[w*L +: L] = m;
    wdata[w*W +: W] = d;
  endtask

  task automatic rd(input int k, input logic [A-1:0] a);
    ren[k]          = 1'b1;
    raddr[k*A +: A] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic any_bad;
    logic [W-1:0] pipe_exp [4];

    // Reset state
    tick();
    tick();
    check("rst_ready", l1_ready, 0);
    check("rst_valids", l1_rvalid, 0);
    check("rst_datas", l1_rdata, 0);
    check("rst_conflict", l1_conf, 0);

    // Release; hammer accesses during clear, then reset again at clear_addr=9
    reset = 1'b1;
    wr(0, 0, 2'b11, 16'hFFFF);
    wr(1, 5, 2'b11, 16'hFFFF);
    wr(2, 31, 2'b11, 16'hFFFF);
    rd(0, 0); rd(1, 5); rd(2, 9);
    tick();
    check("noclear_ready_1cyc", nc_ready, 1);
    check("clear_not_ready_1", l1_ready, 0);
    repeat (8) tick();
    check("clear_not_ready_9", l1_ready, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cnt = 0;
    any_bad = 1'b0;
    while (cnt < 40) begin
      tick();
      cnt++;
      if (l1_ready) break;
      if (l1_rvalid != 0 || l2_rvalid != 0 || l0_rvalid != 0 || l1_rdata != 0 || l1_conf)
        any_bad = 1'b1;
    end
    idle();
    check("clear_cycles", cnt, 16);
    check("clear_ignored_access", any_bad, 0);

    // Every word reads zero
    for (int a = 0; a < 16; a++) begin
      rd(0, A'(a)); rd(1, A'(a)); rd(2, A'(15 - a));
      #1;
      check("clear_l0_zero", l0_rdata, 0);
      tick();
      check("clear_l1_zero", l1_rdata, 0);
      check("clear_l1_valid", l1_rvalid, 3'b111);
      if (a > 0) check("clear_l2_valid", l2_rvalid, 3'b111);
    end
    idle();
    tick();

    // Basic write then read
    wr(0, 3, 2'b11, 16'h00A5);
    tick();
    idle();
    rd(1, 3);
    #1;
    check("basic_l0_data", l0_rdata[W +: W], 16'h00A5);
    check("basic_l0_valid", l0_rvalid, 3'b010);
    tick();
    check("basic_l1_data", l1_rdata[W +: W], 16'h00A5);
    check("basic_l1_valid", l1_rvalid, 3'b010);
    idle();
    tick();
    check("basic_l1_valid_drop", l1_rvalid, 3'b000);
    check("basic_l1_hold", l1_rdata[W +: W], 16'h00A5);
    check("basic_l2_valid", l2_rvalid, 3'b010);
    check("basic_l2_data", l2_rdata[W +: W], 16'h00A5);

    // Full-overlap conflict: writer 2 wins, flag pulses once
    wr(0, 5, 2'b11, 16'h1111);
    wr(2, 5, 2'b11, 16'h3333);
    tick();
    check("conf_full_flag", l1_conf, 1);
    check("conf_full_flag_l0", l0_conf, 1);
    idle();
    rd(0, 5);
    tick();
    check("conf_full_pulse", l1_conf, 0);
    check("conf_full_data", l1_rdata[15:0], 16'h3333);
    idle();

    // Lane-disjoint writes merge without conflict
    wr(0, 6, 2'b01, 16'hAA11);
    wr(2, 6, 2'b10, 16'h33BB);
    tick();
    check("conf_disjoint_flag", l1_conf, 0);
    idle();
    rd(0, 6);
    tick();
    check("conf_disjoint_data", l1_rdata[15:0], 16'h3311);
    idle();

    // Partial overlap: per-lane priority, flag set
    wr(0, 9, 2'b11, 16'h1111);
    wr(1, 9, 2'b01, 16'h2222);
    tick();
    check("conf_partial_flag", l1_conf, 1);
    idle();
    rd(0, 9);
    tick();
    check("conf_partial_data", l1_rdata[15:0], 16'h1122);
    idle();

    // Lane mask; three readers on one address
    wr(0, 2, 2'b11, 16'hBEEF);
    tick();
    wr(0, 2, 2'b01, 16'h1234);
    tick();
    idle();
    rd(0, 2); rd(1, 2); rd(2, 2);
    tick();
    check("mask_multi_data", l1_rdata, 48'hBE34_BE34_BE34);
    check("mask_multi_valid", l1_rvalid, 3'b111);
    idle();

    // Read-during-write on addr 7
    wr(0, 7, 2'b11, 16'h0010);
    tick();
    idle();
    wr(1, 7, 2'b11, 16'h0020);
    wr(2, 7, 2'b10, 16'h5500);
    rd(0, 7);
    #1;
    check("rdw_l0_before", l0_rdata[15:0], 16'h0010);
    tick();
    check("rdw_l1_old", l1_rdata[15:0], 16'h0010);
    check("rdw_l0_after", l0_rdata[15:0], 16'h5520);
    idle();
    tick();
    check("rdw_l2_new_valid", l2_rvalid, 3'b001);
    check("rdw_l2_new", l2_rdata[15:0], 16'h5520);

    // Out-of-range addresses
    wr(0, 20, 2'b11, 16'hFFFF);
    wr(1, 20, 2'b11, 16'hFFFF);
    rd(0, 20);
    rd(1, 4);
    tick();
    check("oor_conflict", l1_conf, 0);
    check("oor_read_zero", l1_rdata[15:0], 16'h0000);
    check("oor_valid", l1_rvalid, 3'b011);
    idle();
    rd(0, 4);
    tick();
    check("oor_no_alias", l1_rdata[15:0], 16'h0000);
    idle();
    tick();
    tick();

    // Back-to-back pipelined reads at latency 2
    pipe_exp[0] = 16'h00A5;
    pipe_exp[1] = 16'h3333;
    pipe_exp[2] = 16'h3311;
    rd(0, 3);
    tick();
    rd(0, 5);
    tick();
    check("pipe_l2_d0", l2_rdata[15:0], pipe_exp[0]);
    rd(0, 6);
    tick();
    check("pipe_l2_d1", l2_rdata[15:0], pipe_exp[1]);
    idle();
    tick();
    check("pipe_l2_d2", l2_rdata[15:0], pipe_exp[2]);
    check("pipe_l2_v2", l2_rvalid, 3'b001);
    tick();
    check("pipe_l2_drain", l2_rvalid, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mrmw_mem_fwd.md
Name: mrmw_mem_fwd

Overview:
Parametrised multi-read/multi-write memory; successor to the current flat-packed multi-port memory primitive. Adds:
- per-lane write masks
- deterministic write-conflict priority with a conflict flag
- selectable read latency (0/1/2)
- selectable read-during-write semantics
- a post-reset clear sequencer with a ready output

Drop-in target for lowered multi-port FIRRTL memories that need defined contents and collision behaviour.

Parameters:
DEPTH, 16, number of words
ADDR_BITS, 4, address width per port
WIDTH, 8, data bits per word
READERS, 3, read port count
WRITERS, 3, write port count
MASK_GRAN, 8, data bits per mask lane; WIDTH must be a multiple; LANES = WIDTH/MASK_GRAN
READ_LATENCY, 1, 0 = combinational, 1 or 2 = registered
RDW_MODE, 0, 0 = read returns old data on same-edge collision, 1 = returns newly written data
CLEAR_ON_RESET, 1, 1 = zero every word after reset, 0 = skip clearing

Ports:
clock  in  1  single clock for all ports
reset  in  1  synchronous, active-low reset
read_ens  in  READERS  per-port read enable, port k = bit k
read_addrs  in  ADDR_BITS*READERS  port k at [k*ADDR_BITS +: ADDR_BITS]
read_datas  out  WIDTH*READERS  port k at [k*WIDTH +: WIDTH]
read_valids  out  READERS  data of port k valid this cycle
write_ens  in  WRITERS  per-port write enable
write_masks  in  LANES*WRITERS  per-port lane mask, bit 0 = lane [MASK_GRAN-1:0]
write_addrs  in  ADDR_BITS*WRITERS  packed as for read_addrs
write_datas  in  WIDTH*WRITERS  packed as for read_datas
ready  out  1  high once clearing is done; accesses are accepted only when high
write_conflict  out  1  registered pulse: two or more enabled writers hit the same address with overlapping lanes

Behaviour:
- Reset (reset==0 sampled at posedge):
  - FSM goes to CLEAR, clear_addr=0.
  - ready=0, read_valids=0, read_datas=0, write_conflict=0.
  - Memory array itself is not reset.
- CLEAR state:
  - Writes 0 to mem[clear_addr] each cycle, clear_addr+1.
  - After writing DEPTH-1, goes to RUN. ready=1 on the cycle after the last clear write, i.e. exactly DEPTH cycles after reset release.
  - With CLEAR_ON_RESET=0: goes straight to RUN, ready=1 the first cycle after release.
- Reset mid-CLEAR: clearing restarts at address 0 and takes the full DEPTH cycles.
- While ready=0: all write_ens and read_ens are ignored, read_valids stay 0.
- Writes, in RUN at posedge:
  - For each lane of each address, the highest-index writer with en=1 and mask lane=1 wins.
  - Lanes with no writer are unchanged. Lane-disjoint writes to the same word merge.
- write_conflict:
  - Set the cycle after an edge where ≥2 enabled writers share an address and at least one lane.
  - Cleared otherwise; it does not hold.
- Addresses ≥ DEPTH: writes dropped, reads return 0, no conflict counted.
- READ_LATENCY=0:
  - read_datas[k] = mem[addr] combinationally; read_valids[k] = read_ens[k] & ready.
  - Same-edge writes become visible after the edge. RDW_MODE is ignored.
- READ_LATENCY=1:
  - Data for a read enabled at edge N appears after edge N; read_valids[k] high for that one cycle.
  - With read_ens[k]=0, read_datas[k] holds its last value and valid=0.
- READ_LATENCY=2: one extra output register stage; valid and data are delayed together.
  - Back-to-back reads are fully pipelined, one result per cycle per port.
- Read-during-write at the same edge and same address (latency ≥1):
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the post-write word, with priority and masks applied.
- Multiple readers on the same address are independent and see identical data.

Test Plan:
- Clear sequence (DEPTH=16, CLEAR_ON_RESET=1): reset low 2 cycles then high -> ready=0 for 16 cycles, rises on cycle 16; reading every address afterwards -> 0x00, valid one cycle after each enable.
- Basic write/read (LAT=1): W0 writes addr 3 = 0xA5, full mask; next cycle R1 reads addr 3 -> read_datas[15:8]=0xA5 with read_valids=3'b010 exactly one cycle later.
- Write conflict: W0 writes addr 5 = 0x11 and W2 writes addr 5 = 0x33 on the same edge, full masks -> mem[5]=0x33, write_conflict=1 for exactly one cycle. Same test with disjoint lanes (WIDTH=16, W0 mask 01 = 0x0011, W2 mask 10 = 0x3300) -> mem=0x3311, write_conflict=0.
- Lane mask (WIDTH=16, MASK_GRAN=8): mem[2]=0xBEEF, then write 0x1234 with mask 2'b01 -> read 0xBE34.
- Read-during-write: mem[7]=0x10, then on the same edge write 0x20 and read addr 7 -> RDW_MODE=0 returns 0x10, RDW_MODE=1 returns 0x20; at LAT=2 the result appears two cycles later.
- Reset mid-clear plus ignored accesses: pull reset low when clear_addr=9 and drive write_ens during CLEAR -> after release ready rises after a full 16 cycles, every word reads 0, no writes land.
